// File: rtl/wb_debug_master.sv
// UART-byte command decoder that runs single Wishbone read/write cycles
// and streams back a status byte plus read data.
module wb_debug_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        overrun,
  output logic        busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS, RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_wr;
  logic [1:0]    r_bcnt;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [39:0]   r_resp;
  logic [2:0]    r_rrem;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [3:0]    r_sel;
  logic          r_ovr;

  logic w_op_ok;
  logic w_last;
  logic w_term;
  logic w_ok;
  logic w_fire;
  logic w_start;

  assign w_op_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
  assign w_last  = (r_bcnt == 2'd3);
  assign w_term  = wb_ack | wb_err | (r_tcnt == TMAX);
  assign w_ok    = wb_ack & ~wb_err;
  assign w_fire  = (r_state == RESP) & tx_ready;
  assign w_start = rx_valid & w_last &
                   (((r_state == ADDR) & ~r_wr) | (r_state == DATA));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (rx_valid) w_next = w_op_ok ? ADDR : RESP;
      ADDR:
        if (rx_valid && w_last) w_next = r_wr ? DATA : BUS;
      DATA:
        if (rx_valid && w_last) w_next = BUS;
      BUS:
        if (w_term) w_next = RESP;
      RESP:
        if (tx_ready && r_rrem == 3'd0) w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_resp  <= '0;
      r_rrem  <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (rx_valid) begin
          r_bcnt <= '0;
          if (w_op_ok) begin
            r_wr <= (rx_data == 8'h01);
          end else begin
            r_resp <= {8'hEE, 32'h0};
            r_rrem <= 3'd0;
          end
        end
        ADDR: if (rx_valid) begin
          r_addr <= {r_addr[23:0], rx_data};
          r_bcnt <= r_bcnt + 2'd1;
        end
        DATA: if (rx_valid) begin
          r_wdata <= {r_wdata[23:0], rx_data};
          r_bcnt  <= r_bcnt + 2'd1;
        end
        BUS: begin
          if (rx_valid) r_ovr <= 1'b1;
          if (w_term) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_we   <= 1'b0;
            r_sel  <= '0;
            // read data is reported as zero unless the slave acked cleanly
            r_resp <= w_ok ? {8'hA5, (r_wr ? 32'h0 : wb_dat_i)}
                           : {8'hEE, 32'h0};
            r_rrem <= r_wr ? 3'd0 : 3'd4;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        RESP: begin
          if (rx_valid) r_ovr <= 1'b1;
          if (w_fire) begin
            r_resp <= {r_resp[31:0], 8'h00};
            if (r_rrem != 3'd0) r_rrem <= r_rrem - 3'd1;
          end
        end
        default: ;
      endcase
      if (w_start) begin
        r_cyc  <= 1'b1;
        r_stb  <= 1'b1;
        r_we   <= r_wr;
        r_sel  <= 4'hF;
        r_tcnt <= '0;
      end
    end
  end

  assign wb_adr   = r_addr;
  assign wb_dat_o = r_wdata;
  assign wb_we    = r_we;
  assign wb_sel   = r_sel;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_stb;
  assign tx_data  = r_resp[39:32];
  assign tx_valid = (r_state == RESP);
  assign overrun  = r_ovr;
  assign busy     = (r_state != IDLE);

endmodule
